// File: rtl/cr_rst_pkg.sv
// Shared definitions for the CPU reset sequencer: FSM encoding, counter width
// and the legal ranges of the sequencer parameters.
package cr_rst_pkg;

    localparam int CNT_W     = 5;
    localparam int SYNC_MIN  = 2;
    localparam int SYNC_MAX  = 4;
    localparam int DLY_MIN   = 1;
    localparam int DLY_MAX   = 32;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_BUS  = 3'd1,
        ST_WAIT_CORE = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_ASSERT = 3'd4
    } seq_state_e;

    function automatic bit dly_ok(input int v);
        return (v >= DLY_MIN) && (v <= DLY_MAX);
    endfunction

endpackage

// File: rtl/cr_rst_sync.sv
// Generic N-stage reset synchronizer: asserts asynchronously, releases after
// STAGES rising edges of clk.
module cr_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_i,
    output logic rst_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_o = chain_q[STAGES-1];

endmodule

// File: rtl/cr_rst_seq.sv
// CPU reset sequencer: synchronized release of bus then core reset, stretched
// software reset, sticky software-reset cause flag and a test-mode bypass.
module cr_rst_seq
    import cr_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BUS_DLY     = 4,
    parameter int CORE_DLY    = 8,
    parameter int SW_RST_LEN  = 16
) (
    input  logic forever_cpuclk,
    input  logic cpurst,
    input  logic pad_yy_test_mode,
    input  logic sysreq_rst,
    output logic rst_seq_bus_rst_b,
    output logic rst_seq_core_rst_b,
    output logic rst_seq_busy,
    output logic rst_seq_sw_rst_flag
);

    generate
        if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX || !dly_ok(BUS_DLY)
            || !dly_ok(CORE_DLY) || !dly_ok(SW_RST_LEN)) begin : g_bad_param
            $error("cr_rst_seq: parameter out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] BUS_CMP  = CNT_W'(BUS_DLY - 1);
    localparam logic [CNT_W-1:0] CORE_CMP = CNT_W'(CORE_DLY - 1);
    localparam logic [CNT_W-1:0] SW_CMP   = CNT_W'(SW_RST_LEN - 1);

    logic             sync_rst;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_q, bus_d;
    logic             core_q, core_d;
    logic             busy_q, busy_d;
    logic             flag_q, flag_d;

    cr_rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (forever_cpuclk),
        .arst_i (cpurst),
        .rst_o  (sync_rst)
    );

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            bus_q   <= 1'b0;
            core_q  <= 1'b0;
            busy_q  <= 1'b1;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            core_q  <= core_d;
            busy_q  <= busy_d;
            flag_q  <= flag_d;
        end
    end

    // Output registers change only on the edge that moves the FSM, so the
    // bus release always precedes the core release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        bus_d   = bus_q;
        core_d  = core_q;
        busy_d  = busy_q;
        flag_d  = flag_q;
        case (state_q)
            ST_ASSERT: begin
                cnt_d = '0;
                if (!sync_rst) begin
                    state_d = ST_WAIT_BUS;
                end
            end
            ST_WAIT_BUS: begin
                if (cnt_q == BUS_CMP) begin
                    state_d = ST_WAIT_CORE;
                    cnt_d   = '0;
                    bus_d   = 1'b1;
                end
            end
            ST_WAIT_CORE: begin
                if (cnt_q == CORE_CMP) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    core_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (sysreq_rst) begin
                    state_d = ST_SW_ASSERT;
                    bus_d   = 1'b0;
                    core_d  = 1'b0;
                    busy_d  = 1'b1;
                    flag_d  = 1'b1;
                end
            end
            ST_SW_ASSERT: begin
                if (cnt_q == SW_CMP) begin
                    state_d = ST_WAIT_BUS;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase
        if (sync_rst) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            bus_d   = 1'b0;
            core_d  = 1'b0;
            busy_d  = 1'b1;
        end
    end

    assign rst_seq_bus_rst_b   = pad_yy_test_mode ? ~cpurst : bus_q;
    assign rst_seq_core_rst_b  = pad_yy_test_mode ? ~cpurst : core_q;
    assign rst_seq_busy        = pad_yy_test_mode ? cpurst  : busy_q;
    assign rst_seq_sw_rst_flag = pad_yy_test_mode ? 1'b0    : flag_q;

    always_comb begin : inv_chk
        assert (!rst_seq_core_rst_b || rst_seq_bus_rst_b);
    end

endmodule
